// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Moore control sequencer for the multicycle RV64 subset core
//   (R-type, I-type ALU, ld, sd, beq). A shared instruction/data memory
//   completes each access with a mem_ready handshake. The sequencer also
//   traps on illegal opcodes and memory timeouts, and it counts retired
//   instructions.
//
//   The datapath enables and mux selects are registered from the next-state
//   decode, so each one is valid during the same cycle as its state. Two
//   kinds of gating are then applied combinationally:
//     - PCWrite and IRWrite follow mem_ready while in FETCH.
//     - While reset is low, every write enable and MemRead is forced to 0.
//
// Ports
//   clk          clock; every state change happens on the rising edge
//   reset        synchronous reset, active low
//   opcode       IR[6:0]; stable from DECODE onward
//   mem_ready    the current memory read or write completes this cycle
//   PCWrite .. ALUOp   datapath enables and mux selects
//   state        current state encoding, for debug
//   trap         sticky fault flag
//   trap_cause   00 none, 01 illegal opcode, 10 memory timeout
//   retired      count of completed instructions (wraps)
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4 on ready
//   DECODE | classify opcode, ALUOut <= PC + (imm<<1)
//   MEMADR | ALUOut <= rs1 + imm
//   MEMRD  | read data memory at ALUOut
//   MEMWB  | rd <= memory data
//   MEMWR  | write data memory at ALUOut
//   EXEC   | ALU operation on rs1 and rs2/imm
//   ALUWB  | rd <= ALUOut
//   BRANCH | compare rs1, rs2; PC <= ALUOut if equal
//   TRAP   | halted until reset
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // The timeout counter only has to reach TIMEOUT-1.
  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic       fetch;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t           state_q, state_nxt;
  ctrl_t            ctrl_q;
  logic [1:0]       cause_nxt;
  logic [1:0]       cause_q;
  logic             trap_q;
  logic [TW-1:0]    to_cnt;
  logic [CNT_W-1:0] retired_q;
  logic             retire_evt;

  // Moore output table: any field not set for a state stays 0.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        c.alu_src_b = (op == OP_I) ? 2'b10 : 2'b00;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // A wait state traps only when the counter is at its last value and the
  // memory is still not ready; mem_ready in that same cycle wins.
  always_comb begin
    state_nxt = state_q;
    cause_nxt = 2'b00;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_nxt = S_DECODE;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (opcode == OP_LD || opcode == OP_SD) begin
          state_nxt = S_MEMADR;
        end else if (opcode == OP_R || opcode == OP_I) begin
          state_nxt = S_EXEC;
        end else if (opcode == OP_BEQ) begin
          state_nxt = S_BRANCH;
        end else begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end
      end
      S_MEMADR: state_nxt = (opcode == OP_LD) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready) begin
          state_nxt = S_MEMWB;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: state_nxt = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) begin
          state_nxt = S_FETCH;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_EXEC:   state_nxt = S_ALUWB;
      S_ALUWB:  state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  assign retire_evt = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                      (state_q == S_BRANCH) ||
                      ((state_q == S_MEMWR) && mem_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode_ctrl(S_FETCH, opcode);
      cause_q   <= 2'b00;
      trap_q    <= 1'b0;
      to_cnt    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= decode_ctrl(state_nxt, opcode);

      // The counter restarts on every state change and advances only while
      // the memory is stalling, so it measures the current wait alone.
      if (state_nxt != state_q) begin
        to_cnt <= '0;
      end else if (!mem_ready) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (state_q != S_TRAP && state_nxt == S_TRAP) begin
        cause_q <= cause_nxt;
        trap_q  <= 1'b1;
      end

      if (retire_evt) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign PCWrite     = reset & ctrl_q.fetch & mem_ready;
  assign IRWrite     = reset & ctrl_q.fetch & mem_ready;
  assign PCWriteCond = reset & ctrl_q.pc_write_cond;
  assign MemRead     = reset & ctrl_q.mem_read;
  assign MemWrite    = reset & ctrl_q.mem_write;
  assign RegWrite    = reset & ctrl_q.reg_write;
  assign PCSource    = ctrl_q.pc_source;
  assign IorD        = ctrl_q.iord;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign state       = state_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Directed bench for multicycle_control_fsm. A table of per-cycle vectors
//   covers reset, R/I/ld/sd/beq sequencing, wait states and a reset in the
//   middle of an instruction. Hand-written sequences then cover the trap
//   paths, the timeout boundary and counter wrap. A second instance with a
//   3-bit counter sees the same stimulus and is used for the wrap case.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Control bits: {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
  //                IRWrite, MemtoReg, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0]}
  localparam logic [13:0] C_RST    = 14'b00000000000100;
  localparam logic [13:0] C_FETCH  = 14'b10001010000100;
  localparam logic [13:0] C_FWAIT  = 14'b00001000000100;
  localparam logic [13:0] C_DEC    = 14'b00000000001100;
  localparam logic [13:0] C_MADR   = 14'b00000000011000;
  localparam logic [13:0] C_MRD    = 14'b00011000000000;
  localparam logic [13:0] C_MWB    = 14'b00000001100000;
  localparam logic [13:0] C_MWR    = 14'b00010100000000;
  localparam logic [13:0] C_EXEC_R = 14'b00000000010010;
  localparam logic [13:0] C_EXEC_I = 14'b00000000011010;
  localparam logic [13:0] C_AWB    = 14'b00000000100000;
  localparam logic [13:0] C_BR     = 14'b01100000010001;
  localparam logic [13:0] C_NONE   = 14'b00000000000000;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite;
  logic        IRWrite, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  logic        w_PCWrite, w_PCWriteCond, w_PCSource, w_IorD, w_MemRead, w_MemWrite;
  logic        w_IRWrite, w_MemtoReg, w_RegWrite, w_ALUSrcA;
  logic [1:0]  w_ALUSrcB, w_ALUOp;
  logic [3:0]  w_state;
  logic        w_trap;
  logic [1:0]  w_trap_cause;
  logic [2:0]  w_retired;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_fsm #(.CNT_W(32), .TIMEOUT(16)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  multicycle_control_fsm #(.CNT_W(3), .TIMEOUT(16)) u_wrap (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(w_PCWrite), .PCWriteCond(w_PCWriteCond), .PCSource(w_PCSource),
    .IorD(w_IorD), .MemRead(w_MemRead), .MemWrite(w_MemWrite),
    .IRWrite(w_IRWrite), .MemtoReg(w_MemtoReg), .RegWrite(w_RegWrite),
    .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .ALUOp(w_ALUOp),
    .state(w_state), .trap(w_trap), .trap_cause(w_trap_cause),
    .retired(w_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [13:0] ctl;
    int          ret;
  } vec_t;

  vec_t tv[$];

  function automatic logic [13:0] ctl_now();
    return {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    mem_ready = 1'b1;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // rst, opcode, mem_ready, expected state, controls, retired
    tv.push_back('{1'b0, OP_R,   1'b1, 4'd0, C_RST,    0});
    tv.push_back('{1'b0, OP_R,   1'b1, 4'd0, C_RST,    0});
    tv.push_back('{1'b0, OP_R,   1'b1, 4'd0, C_RST,    0});
    tv.push_back('{1'b1, OP_R,   1'b1, 4'd0, C_FETCH,  0});
    tv.push_back('{1'b1, OP_R,   1'b1, 4'd1, C_DEC,    0});
    tv.push_back('{1'b1, OP_R,   1'b1, 4'd6, C_EXEC_R, 0});
    tv.push_back('{1'b1, OP_R,   1'b1, 4'd7, C_AWB,    0});
    tv.push_back('{1'b1, OP_I,   1'b1, 4'd0, C_FETCH,  1});
    tv.push_back('{1'b1, OP_I,   1'b1, 4'd1, C_DEC,    1});
    tv.push_back('{1'b1, OP_I,   1'b1, 4'd6, C_EXEC_I, 1});
    tv.push_back('{1'b1, OP_I,   1'b1, 4'd7, C_AWB,    1});
    tv.push_back('{1'b1, OP_LD,  1'b1, 4'd0, C_FETCH,  2});
    tv.push_back('{1'b1, OP_LD,  1'b1, 4'd1, C_DEC,    2});
    tv.push_back('{1'b1, OP_LD,  1'b1, 4'd2, C_MADR,   2});
    tv.push_back('{1'b1, OP_LD,  1'b0, 4'd3, C_MRD,    2});
    tv.push_back('{1'b1, OP_LD,  1'b0, 4'd3, C_MRD,    2});
    tv.push_back('{1'b1, OP_LD,  1'b0, 4'd3, C_MRD,    2});
    tv.push_back('{1'b1, OP_LD,  1'b1, 4'd3, C_MRD,    2});
    tv.push_back('{1'b1, OP_LD,  1'b1, 4'd4, C_MWB,    2});
    tv.push_back('{1'b1, OP_SD,  1'b1, 4'd0, C_FETCH,  3});
    tv.push_back('{1'b1, OP_SD,  1'b1, 4'd1, C_DEC,    3});
    tv.push_back('{1'b1, OP_SD,  1'b1, 4'd2, C_MADR,   3});
    tv.push_back('{1'b1, OP_SD,  1'b0, 4'd5, C_MWR,    3});
    tv.push_back('{1'b1, OP_SD,  1'b1, 4'd5, C_MWR,    3});
    tv.push_back('{1'b1, OP_BEQ, 1'b1, 4'd0, C_FETCH,  4});
    tv.push_back('{1'b1, OP_BEQ, 1'b1, 4'd1, C_DEC,    4});
    tv.push_back('{1'b1, OP_BEQ, 1'b1, 4'd8, C_BR,     4});
    tv.push_back('{1'b1, OP_R,   1'b0, 4'd0, C_FWAIT,  5});
    tv.push_back('{1'b1, OP_R,   1'b1, 4'd0, C_FETCH,  5});
    tv.push_back('{1'b1, OP_R,   1'b1, 4'd1, C_DEC,    5});
    tv.push_back('{1'b0, OP_R,   1'b1, 4'd6, C_EXEC_R, 5});
    tv.push_back('{1'b1, OP_R,   1'b1, 4'd0, C_FETCH,  0});

    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_R;
    tick();

    for (int i = 0; i < tv.size(); i++) begin
      reset     = tv[i].rst;
      opcode    = tv[i].op;
      mem_ready = tv[i].rdy;
      #1;
      chk($sformatf("row%0d state", i),   64'(state),     64'(tv[i].st));
      chk($sformatf("row%0d ctl", i),     64'(ctl_now()), 64'(tv[i].ctl));
      chk($sformatf("row%0d retired", i), 64'(retired),   64'(tv[i].ret));
      tick();
    end

    // Illegal opcode: trap is sticky, the cause is held and everything is off.
    do_reset();
    opcode    = OP_BAD;
    mem_ready = 1'b1;
    tick();
    chk("ill decode state", 64'(state), 64'd1);
    tick();
    chk("ill trap state", 64'(state), 64'd9);
    chk("ill trap cause", 64'(trap_cause), 64'd1);
    chk("ill trap ctl", 64'(ctl_now()), 64'(C_NONE));
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("ill hold%0d state", k), 64'(state), 64'd9);
      chk($sformatf("ill hold%0d trap", k), 64'(trap), 64'd1);
      chk($sformatf("ill hold%0d cause", k), 64'(trap_cause), 64'd1);
    end
    chk("ill trap retired", 64'(retired), 64'd0);
    chk("ill trap ctl late", 64'(ctl_now()), 64'(C_NONE));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    opcode = OP_R;
    #1;
    chk("ill reset state", 64'(state), 64'd0);
    chk("ill reset trap", 64'(trap), 64'd0);
    chk("ill reset cause", 64'(trap_cause), 64'd0);

    // Fetch timeout: trap 16 cycles after FETCH entry.
    do_reset();
    mem_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("to wait%0d state", k), 64'(state), 64'd0);
      tick();
    end
    chk("to trap state", 64'(state), 64'd9);
    chk("to trap cause", 64'(trap_cause), 64'd2);
    tick();
    chk("to trap flag", 64'(trap), 64'd1);

    // Ready on the 16th cycle wins over the timeout.
    do_reset();
    mem_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
    end
    chk("edge wait state", 64'(state), 64'd0);
    mem_ready = 1'b1;
    #1;
    chk("edge wait ctl", 64'(ctl_now()), 64'(C_FETCH));
    tick();
    chk("edge decode state", 64'(state), 64'd1);
    chk("edge no trap", 64'(trap), 64'd0);
    chk("edge no cause", 64'(trap_cause), 64'd0);

    // Counter wrap on the 3-bit instance: eight beq instructions.
    do_reset();
    opcode    = OP_BEQ;
    mem_ready = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      tick();
      tick();
      chk($sformatf("wrap main retired%0d", n), 64'(retired), 64'(n));
      chk($sformatf("wrap small retired%0d", n), 64'(w_retired), 64'(n % 8));
    end
    chk("wrap small state", 64'(w_state), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore control state machine that sequences a multicycle build of the RV64 subset core: R-type, I-type ALU, ld, sd, beq.
- One shared instruction/data memory with a ready handshake; instruction register (IR), ALUOut and PC registers are in the datapath.
- Replaces the single-cycle ControlUnit. Drives all datapath enables and mux selects.
- Adds an illegal-opcode/memory-timeout trap and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 16, maximum cycles to wait for mem_ready in any memory wait state; must be at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- opcode  in  7  instruction[6:0] from the IR; stable from DECODE onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when the ALU Zero output is 1.
- PCSource  out  1  0 selects ALU result (PC+4); 1 selects ALUOut (branch target).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = memory data register.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs1.
- ALUSrcB  out  2  ALU B input: 00 = rs2, 01 = constant 4, 10 = imm, 11 = imm<<1.
- ALUOp  out  2  to ALUControl: 00 = add, 01 = sub, 10 = use funct.
- state  out  4  current state encoding, for debug.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, TRAP=9.
- Any output or signal not listed for a state is 0.
- Reset:
  - state=FETCH, trap=0, trap_cause=00, retired=0, timeout counter=0.
  - While reset==0, every write enable (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) and MemRead is forced to 0.
  - Reset mid-instruction abandons the instruction; the next cycle is FETCH.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite=PCWrite=mem_ready.
  - Next state DECODE if mem_ready, otherwise FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00; this precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 or 0010011 -> EXEC.
    - 1100011 -> BRANCH.
    - Any other opcode -> TRAP with cause 01.
- MEMADR:
  - ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state MEMRD if opcode is a load, otherwise MEMWR.
- MEMRD: MemRead=1, IorD=1; next state MEMWB on mem_ready, otherwise stay.
- MEMWB: RegWrite=1, MemtoReg=1; next state FETCH.
- MEMWR:
  - MemWrite=1, IorD=1, held until mem_ready.
  - Next state FETCH on mem_ready.
- EXEC:
  - ALUSrcA=1, ALUOp=10.
  - ALUSrcB=00 for opcode 0110011, 10 for opcode 0010011.
  - Next state ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0; next state FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1.
  - Next state FETCH.
- TRAP:
  - All enables 0; state is held until reset.
  - trap=1 from the cycle after entry.
  - trap_cause is latched at entry and never overwritten.
- retired:
  - Increments by 1 on each clock edge that leaves MEMWB, ALUWB or BRANCH, or that leaves MEMWR with mem_ready=1.
  - Wraps from all-ones to 0 with no flag.
  - Not incremented on entry to TRAP.
- Timeout (FETCH, MEMRD, MEMWR):
  - The counter clears on entry to each of these states and increments each cycle mem_ready=0.
  - If the counter reaches TIMEOUT-1 with mem_ready=0, next state is TRAP with cause 10.
  - mem_ready=1 on that same cycle wins and the normal transition is taken.
- Latency per instruction with mem_ready tied to 1: R/I-type 4 cycles, ld 5, sd 4, beq 3.

Test Plan:
- Hold reset=0 for 3 cycles with mem_ready=1 -> PCWrite=IRWrite=0 throughout; after release, state=0 and retired=0.
- mem_ready=1, opcode=0110011 -> state sequence 0,1,6,7,0; ALUSrcB=00 and ALUOp=10 in EXEC; RegWrite=1 only in ALUWB; retired=1.
- opcode=0000011, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles; MEMWB asserts RegWrite=1, MemtoReg=1; retired increments once.
- opcode=1100011 -> sequence 0,1,8,0; ALUSrcB=11 in DECODE; PCWriteCond=1, ALUOp=01 in BRANCH.
- opcode=1111111 -> TRAP (state=9), trap=1, trap_cause=01 held for 20 cycles; reset pulse returns state=0 and trap=0.
- mem_ready=0 in FETCH with TIMEOUT=16 -> TRAP entered exactly 16 cycles after FETCH entry, trap_cause=10.
- Separately, mem_ready=1 on the 16th cycle -> DECODE is entered and no trap occurs.
- Separately, preload retired=2^CNT_W-1 via a forced state and complete one instruction -> retired=0.
